// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake bundle between fetch, the decode stage and execute.
// The fetch-side request (in_*) and the decoded packet (out_*) travel together.
// The stage itself connects through the slave modport. The environment around
// the stage connects through the master modport.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic            rd_we;
    logic            rs1_use;
    logic            rs2_use;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, funct3, funct7,
               imm, fmt, illegal, rd_we, rs1_use, rs2_use
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, funct3, funct7,
               imm, fmt, illegal, rd_we, rs1_use, rs2_use
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode stage between fetch and execute.
// The stage splits the instruction into its fields, builds the sign-extended
// immediate and classifies the format. It flags illegal encodings and derives
// the register-use bits.
// Optional feature macro: DECODE_SKID_EN. When it is defined, a one-entry skid
// buffer is added and in_ready becomes a registered "skid empty" signal.
// Otherwise in_ready follows out_ready combinationally.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd7;

    localparam bit RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic            rd_we;
        logic            rs1_use;
        logic            rs2_use;
    } packet_t;

    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [2:0]  fmt;
    logic [31:0] imm32;
    packet_t     dec;

    assign instr = bus.in_instr;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    // Decide the format and whether the encoding is in the supported set.
    // Any opcode outside the listed set, including RV64 W-opcodes, ends up illegal.
    always_comb begin
        legal = 1'b0;
        fmt   = FMT_BAD;
        case (opc)
            OP_LUI, OP_AUIPC: begin legal = 1'b1; fmt = FMT_U; end
            OP_JAL:           begin legal = 1'b1; fmt = FMT_J; end
            OP_JALR:          begin legal = (f3 == 3'b000); fmt = FMT_I; end
            OP_BRANCH:        begin legal = (f3 != 3'b010) && (f3 != 3'b011); fmt = FMT_B; end
            OP_LOAD: begin
                fmt = FMT_I;
                case (f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                    3'b011, 3'b110:                         legal = RV64;
                    default:                                legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                fmt   = FMT_S;
                legal = (f3 <= 3'b010) || (RV64 && (f3 == 3'b011));
            end
            OP_IMM: begin
                fmt = FMT_I;
                case (f3)
                    3'b001:  legal = RV64 ? (instr[31:26] == 6'b000000)
                                          : (f7 == 7'b0000000);
                    3'b101:  legal = RV64 ? ((instr[31:26] == 6'b000000) ||
                                             (instr[31:26] == 6'b010000))
                                          : ((f7 == 7'b0000000) || (f7 == 7'b0100000));
                    default: legal = 1'b1;
                endcase
            end
            OP_OP: begin
                fmt   = FMT_R;
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OP_FENCE:  begin legal = 1'b1; fmt = FMT_I; end
            OP_SYSTEM: begin
                legal = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
                fmt   = FMT_I;
            end
            default: begin legal = 1'b0; fmt = FMT_BAD; end
        endcase
        if (!legal) begin
            fmt = FMT_BAD;
        end
    end

    // Build the 32-bit immediate for the chosen format. R-type and illegal give 0.
    always_comb begin
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'b0;
        endcase
    end

    // Assemble the packet that gets registered when the instruction is accepted.
    always_comb begin
        dec         = '0;
        dec.pc      = bus.in_pc;
        dec.opcode  = opc;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = f3;
        dec.funct7  = f7;
        dec.imm     = XLEN'($signed(imm32));
        dec.fmt     = fmt;
        dec.illegal = !legal;
        dec.rd_we   = legal && (instr[11:7] != 5'd0) &&
                      ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J));
        dec.rs1_use = legal && ((fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B) ||
                      ((fmt == FMT_I) && (opc != OP_FENCE) && (opc != OP_SYSTEM)));
        dec.rs2_use = legal && ((fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B));
    end

    packet_t out_q;
    logic    out_valid_q;
    logic    in_ready;
    logic    push;
    logic    pop;

`ifdef DECODE_SKID_EN
    packet_t skid_q;
    logic    skid_valid_q;

    assign in_ready = !skid_valid_q || flush;
`else
    assign in_ready = !out_valid_q || bus.out_ready || flush;
`endif

    assign push = bus.in_valid && in_ready;
    assign pop  = out_valid_q && bus.out_ready;

`ifdef DECODE_SKID_EN
    // Output slot plus one skid entry. The skid entry always drains into the output slot first, which preserves order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (push) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (push) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end
`else
    // Single output register. A push while the old packet pops replaces it on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (push) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_q.pc;
    assign bus.opcode    = out_q.opcode;
    assign bus.rd        = out_q.rd;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.funct3    = out_q.funct3;
    assign bus.funct7    = out_q.funct7;
    assign bus.imm       = out_q.imm;
    assign bus.fmt       = out_q.fmt;
    assign bus.illegal   = out_q.illegal;
    assign bus.rd_we     = out_q.rd_we;
    assign bus.rs1_use   = out_q.rs1_use;
    assign bus.rs2_use   = out_q.rs2_use;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based reference model that decodes straight from the ISA field rules.
// Both build variants are handled; DECODE_SKID_EN selects capacity 2.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam bit RV64 = (XLEN == 64);

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
        logic        rd_we;
        logic        rs1_use;
        logic        rs2_use;
    } pkt_t;

    logic clk;
    logic rst;
    logic flush;
    int   compared;
    int   mismatched;

    pkt_t        model[$];
    logic [31:0] seenPc[$];

    decode_stage_if #(.XLEN(XLEN)) bus();

    decode_stage #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode computed from the ISA rules with plain arithmetic
    function automatic pkt_t refDecode(input logic [31:0] w, input logic [31:0] pc);
        pkt_t        p;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] sx;
        bit          ok;
        int          kind;
        op   = w[6:0];
        f3   = w[14:12];
        f7   = w[31:25];
        sx   = w[31] ? 32'hFFFF_FFFF : 32'h0;
        ok   = 0;
        kind = 7;
        if (op == 7'h37 || op == 7'h17) begin ok = 1; kind = 4; end
        else if (op == 7'h6F) begin ok = 1; kind = 5; end
        else if (op == 7'h67) begin ok = (f3 == 3'd0); kind = 1; end
        else if (op == 7'h63) begin ok = !(f3 == 3'd2 || f3 == 3'd3); kind = 3; end
        else if (op == 7'h03) begin
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (RV64 && (f3 inside {3'd3, 3'd6}));
            kind = 1;
        end
        else if (op == 7'h23) begin ok = (f3 <= 3'd2) || (RV64 && f3 == 3'd3); kind = 2; end
        else if (op == 7'h13) begin
            kind = 1;
            if (f3 == 3'd1)      ok = RV64 ? (w[31:26] == 6'h00) : (f7 == 7'h00);
            else if (f3 == 3'd5) ok = RV64 ? (w[31:26] == 6'h00 || w[31:26] == 6'h10)
                                           : (f7 == 7'h00 || f7 == 7'h20);
            else                 ok = 1;
        end
        else if (op == 7'h33) begin ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); kind = 0; end
        else if (op == 7'h0F) begin ok = 1; kind = 1; end
        else if (op == 7'h73) begin ok = (w == 32'h0000_0073) || (w == 32'h0010_0073); kind = 1; end
        if (!ok) kind = 7;
        p        = '0;
        p.pc     = pc;
        p.opcode = op;
        p.rd     = w[11:7];
        p.rs1    = w[19:15];
        p.rs2    = w[24:20];
        p.funct3 = f3;
        p.funct7 = f7;
        p.fmt    = 3'(kind);
        case (kind)
            1:       p.imm = (sx << 12) | 32'(w[31:20]);
            2:       p.imm = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
            3:       p.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            4:       p.imm = w & 32'hFFFF_F000;
            5:       p.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            default: p.imm = 32'h0;
        endcase
        p.illegal = !ok;
        p.rd_we   = ok && (kind == 0 || kind == 1 || kind == 4 || kind == 5) && (w[11:7] != 5'd0);
        p.rs1_use = ok && (kind == 0 || kind == 2 || kind == 3 || (kind == 1 && op != 7'h0F && op != 7'h73));
        p.rs2_use = ok && (kind == 0 || kind == 2 || kind == 3);
        return p;
    endfunction

    // Expected in_ready from the number of packets the model holds
    function automatic bit modelReady(input logic ordy, input logic fl);
`ifdef DECODE_SKID_EN
        return (model.size() < 2) || fl;
`else
        return (model.size() == 0) || ordy || fl;
`endif
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input bit rdy);
        pkt_t e;
        checkValue({tag, ":in_ready"}, 64'(bus.in_ready), 64'(rdy));
        checkValue({tag, ":out_valid"}, 64'(bus.out_valid), 64'(model.size() > 0));
        if (model.size() > 0) begin
            e = model[0];
            checkValue({tag, ":pc"},      64'(bus.out_pc),  64'(e.pc));
            checkValue({tag, ":opcode"},  64'(bus.opcode),  64'(e.opcode));
            checkValue({tag, ":rd"},      64'(bus.rd),      64'(e.rd));
            checkValue({tag, ":rs1"},     64'(bus.rs1),     64'(e.rs1));
            checkValue({tag, ":rs2"},     64'(bus.rs2),     64'(e.rs2));
            checkValue({tag, ":funct3"},  64'(bus.funct3),  64'(e.funct3));
            checkValue({tag, ":funct7"},  64'(bus.funct7),  64'(e.funct7));
            checkValue({tag, ":imm"},     64'(bus.imm),     64'(e.imm));
            checkValue({tag, ":fmt"},     64'(bus.fmt),     64'(e.fmt));
            checkValue({tag, ":illegal"}, 64'(bus.illegal), 64'(e.illegal));
            checkValue({tag, ":rd_we"},   64'(bus.rd_we),   64'(e.rd_we));
            checkValue({tag, ":rs1_use"}, 64'(bus.rs1_use), 64'(e.rs1_use));
            checkValue({tag, ":rs2_use"}, 64'(bus.rs2_use), 64'(e.rs2_use));
        end
    endtask

    // Drive one cycle, check against the model, then advance model and clock
    task automatic applyStimulus(input string tag, input logic v, input logic [31:0] ins,
                                 input logic [31:0] pc, input logic ordy, input logic fl,
                                 input logic rs, output bit accepted);
        bit rdy;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        rst           = rs;
        #1;
        rdy = modelReady(ordy, fl);
        if (!rs) begin
            checkOutput(tag, rdy);
            if (bus.out_valid === 1'b1 && ordy && !fl) seenPc.push_back(bus.out_pc);
        end
        accepted = 0;
        if (rs || fl) begin
            model.delete();
        end else begin
            if (model.size() > 0 && ordy) void'(model.pop_front());
            if (v && rdy) begin
                model.push_back(refDecode(ins, pc));
                accepted = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  opTable[13];
    logic [31:0] stallInstr[3];
    logic [31:0] stallPc[3];

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] ins;
        logic [31:0] pc;
        int          pick;

        compared   = 0;
        mismatched = 0;
        opTable    = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                       7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B};

        // Reset and the state right after it
        applyStimulus("rst0", 0, 32'h0, 32'h0, 0, 0, 1, acc);
        applyStimulus("rst1", 0, 32'h0, 32'h0, 0, 0, 1, acc);
        bus.in_valid = 0; bus.out_ready = 0; flush = 0; rst = 0;
        #1;
        checkValue("reset.out_valid", 64'(bus.out_valid), 64'h0);
        checkValue("reset.in_ready",  64'(bus.in_ready),  64'h1);
        checkValue("reset.imm",       64'(bus.imm),       64'h0);
        checkValue("reset.fmt",       64'(bus.fmt),       64'h0);
        checkValue("reset.rd_we",     64'(bus.rd_we),     64'h0);
        checkValue("reset.out_pc",    64'(bus.out_pc),    64'h0);

        // Spec example instructions with explicit constant expectations
        applyStimulus("addi", 1, 32'hFFF0_0093, 32'h100, 1, 0, 0, acc);
        checkValue("addi.out_valid", 64'(bus.out_valid), 64'h1);
        checkValue("addi.rd",        64'(bus.rd),        64'h1);
        checkValue("addi.rs1",       64'(bus.rs1),       64'h0);
        checkValue("addi.fmt",       64'(bus.fmt),       64'h1);
        checkValue("addi.imm",       64'(bus.imm),       64'hFFFF_FFFF);
        checkValue("addi.rd_we",     64'(bus.rd_we),     64'h1);
        checkValue("addi.rs2_use",   64'(bus.rs2_use),   64'h0);
        applyStimulus("beq", 1, 32'hFE00_0EE3, 32'h104, 1, 0, 0, acc);
        checkValue("beq.fmt",     64'(bus.fmt),     64'h3);
        checkValue("beq.imm",     64'(bus.imm),     64'hFFFF_FFFC);
        checkValue("beq.rd_we",   64'(bus.rd_we),   64'h0);
        checkValue("beq.rs1_use", 64'(bus.rs1_use), 64'h1);
        checkValue("beq.rs2_use", 64'(bus.rs2_use), 64'h1);
        applyStimulus("sw", 1, 32'h0020_A423, 32'h108, 1, 0, 0, acc);
        checkValue("sw.fmt", 64'(bus.fmt), 64'h2);
        checkValue("sw.imm", 64'(bus.imm), 64'h8);
        checkValue("sw.rs1", 64'(bus.rs1), 64'h1);
        checkValue("sw.rs2", 64'(bus.rs2), 64'h2);
        applyStimulus("ecall", 1, 32'h0000_0073, 32'h10C, 1, 0, 0, acc);
        checkValue("ecall.illegal", 64'(bus.illegal), 64'h0);
        applyStimulus("zero", 1, 32'h0000_0000, 32'h110, 1, 0, 0, acc);
        checkValue("zero.illegal", 64'(bus.illegal), 64'h1);
        checkValue("zero.fmt",     64'(bus.fmt),     64'h7);
        checkValue("zero.imm",     64'(bus.imm),     64'h0);
        applyStimulus("drain0", 0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Back-to-back A,B,C with three stalled cycles, then release
        stallInstr = '{32'h0020_81B3, 32'h0000_A283, 32'h0100_00EF};
        stallPc    = '{32'h200, 32'h204, 32'h208};
        seenPc.delete();
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus("stall", idx < 3, stallInstr[idx < 3 ? idx : 0],
                          stallPc[idx < 3 ? idx : 0], c >= 3, 0, 0, acc);
            if (acc) idx++;
        end
        checkValue("stall.count", 64'(seenPc.size()), 64'h3);
        for (int i = 0; i < 3; i++) begin
            if (i < seenPc.size()) checkValue("stall.order", 64'(seenPc[i]), 64'(stallPc[i]));
        end

        // Flush while stalled with storage full; same-cycle input is dropped
        applyStimulus("flushA", 1, 32'hFFF0_0093, 32'h300, 0, 0, 0, acc);
        applyStimulus("flushB", 1, 32'h0020_A423, 32'h304, 0, 0, 0, acc);
        applyStimulus("flushB2", 1, 32'h0020_A423, 32'h304, 0, 0, 0, acc);
        applyStimulus("flushD", 1, 32'h0000_0073, 32'h30C, 0, 1, 0, acc);
        checkValue("flush.out_valid", 64'(bus.out_valid), 64'h0);
        applyStimulus("flushIdle", 0, 32'h0, 32'h0, 1, 0, 0, acc);
        applyStimulus("flushE", 1, 32'hFE00_0EE3, 32'h310, 1, 0, 0, acc);
        checkValue("flushE.imm", 64'(bus.imm), 64'hFFFF_FFFC);
        applyStimulus("flushE2", 0, 32'h0, 32'h0, 1, 0, 0, acc);

        // Reset while a packet is stalled at the output
        applyStimulus("mrstA", 1, 32'hFFF0_0093, 32'h400, 0, 0, 0, acc);
        applyStimulus("mrst", 0, 32'h0, 32'h0, 0, 0, 1, acc);
        bus.in_valid = 0; bus.out_ready = 0; flush = 0; rst = 0;
        #1;
        checkValue("mrst.out_valid", 64'(bus.out_valid), 64'h0);
        checkValue("mrst.imm",       64'(bus.imm),       64'h0);
        checkValue("mrst.in_ready",  64'(bus.in_ready),  64'h1);

        // Randomized traffic: mixed opcodes, random handshakes, rare flushes
        pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            ins  = $urandom;
            pick = int'($urandom_range(0, 15));
            if (pick < 13) ins[6:0] = opTable[pick];
            else if (pick == 13) ins = 32'h0000_0073;
            else if (pick == 14) ins = 32'h0010_0073;
            if (pick < 13 && $urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            applyStimulus("rand", $urandom_range(0, 3) != 0, ins, pc,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 0, acc);
            if (acc) pc = pc + 32'd4;
        end
        for (int c = 0; c < 4; c++) applyStimulus("final", 0, 32'h0, 32'h0, 1, 0, 0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
